// File: rtl/morse_keyer.sv
// rtl/morse_keyer.sv - character code to ITU Morse key timing with unit strobe
module morse_keyer #(
    parameter int UNIT_CYCLES = 5000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic [5:0] char_code,
    output logic       key,
    output logic       busy,
    output logic       unit_tick,
    output logic       done,
    output logic       err
);

    localparam int PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        GAP,
        CGAP
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [1:0]    unit_q, unit_d;
    logic [5:0]    code_q, code_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [7:0]    lut;
    logic [2:0]    len;
    logic [4:0]    pat;
    logic          tick;
    logic          elem_dash;
    logic          mark_last;

    // Morse table: {length, pattern}, pattern bit i set means element i is a dash
    always_comb begin
        lut = {3'd1, 5'b00000};
        case (code_q)
            6'd0:  lut = {3'd2, 5'b00010};
            6'd1:  lut = {3'd4, 5'b00001};
            6'd2:  lut = {3'd4, 5'b00101};
            6'd3:  lut = {3'd3, 5'b00001};
            6'd4:  lut = {3'd1, 5'b00000};
            6'd5:  lut = {3'd4, 5'b00100};
            6'd6:  lut = {3'd3, 5'b00011};
            6'd7:  lut = {3'd4, 5'b00000};
            6'd8:  lut = {3'd2, 5'b00000};
            6'd9:  lut = {3'd4, 5'b01110};
            6'd10: lut = {3'd3, 5'b00101};
            6'd11: lut = {3'd4, 5'b00010};
            6'd12: lut = {3'd2, 5'b00011};
            6'd13: lut = {3'd2, 5'b00001};
            6'd14: lut = {3'd3, 5'b00111};
            6'd15: lut = {3'd4, 5'b00110};
            6'd16: lut = {3'd4, 5'b01011};
            6'd17: lut = {3'd3, 5'b00010};
            6'd18: lut = {3'd3, 5'b00000};
            6'd19: lut = {3'd1, 5'b00001};
            6'd20: lut = {3'd3, 5'b00100};
            6'd21: lut = {3'd4, 5'b01000};
            6'd22: lut = {3'd3, 5'b00110};
            6'd23: lut = {3'd4, 5'b01001};
            6'd24: lut = {3'd4, 5'b01101};
            6'd25: lut = {3'd4, 5'b00011};
            6'd26: lut = {3'd5, 5'b11111};
            6'd27: lut = {3'd5, 5'b11110};
            6'd28: lut = {3'd5, 5'b11100};
            6'd29: lut = {3'd5, 5'b11000};
            6'd30: lut = {3'd5, 5'b10000};
            6'd31: lut = {3'd5, 5'b00000};
            6'd32: lut = {3'd5, 5'b00001};
            6'd33: lut = {3'd5, 5'b00011};
            6'd34: lut = {3'd5, 5'b00111};
            6'd35: lut = {3'd5, 5'b01111};
            default: lut = {3'd1, 5'b00000};
        endcase
    end

    assign len       = lut[7:5];
    assign pat       = lut[4:0];
    assign tick      = (state_q != IDLE) && (presc_q == PW'(UNIT_CYCLES - 1));
    assign elem_dash = pat[idx_q];
    assign mark_last = elem_dash ? (unit_q == 2'd2) : (unit_q == 2'd0);

    // Next-state logic: element sequencing, unit counting inside marks/gaps, handshake pulses
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        idx_d   = idx_q;
        unit_d  = unit_q;
        code_d  = code_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (state_q == IDLE) begin
            presc_d = '0;
            idx_d   = 3'd0;
            unit_d  = 2'd0;
        end else begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (char_code <= 6'd35) begin
                        code_d  = char_code;
                        state_d = MARK;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            MARK: begin
                if (tick) begin
                    if (mark_last) begin
                        unit_d  = 2'd0;
                        state_d = (idx_q == len - 3'd1) ? CGAP : GAP;
                    end else begin
                        unit_d = unit_q + 2'd1;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = MARK;
                end
            end
            CGAP: begin
                if (tick) begin
                    if (unit_q == 2'd2) begin
                        unit_d  = 2'd0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        unit_d = unit_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset that aborts any character in flight
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            presc_q <= '0;
            idx_q   <= 3'd0;
            unit_q  <= 2'd0;
            code_q  <= 6'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            unit_q  <= unit_d;
            code_q  <= code_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign key       = (state_q == MARK);
    assign busy      = (state_q != IDLE);
    assign unit_tick = tick;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_morse_keyer.sv
// tb/tb_morse_keyer.sv - scoreboard bench for morse_keyer against a Morse timing model
module tb_morse_keyer;

    localparam int U = 4;

    logic       CLK;
    logic       RST;
    logic       start;
    logic [5:0] char_code;
    logic       key;
    logic       busy;
    logic       unit_tick;
    logic       done;
    logic       err;

    morse_keyer #(.UNIT_CYCLES(U)) dut (
        .CLK(CLK),
        .RST(RST),
        .start(start),
        .char_code(char_code),
        .key(key),
        .busy(busy),
        .unit_tick(unit_tick),
        .done(done),
        .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    string morse [36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-",
        ".....", "-....", "--...", "---..", "----."
    };

    typedef struct packed {
        logic       is_err;
        logic [5:0] code;
        int         t;
    } exp_t;

    exp_t exp_q[$];
    int   idle_at = 0;

    function automatic int exp_nruns(input int code);
        string s;
        s = morse[code];
        return 2 * s.len();
    endfunction

    // Runs alternate mark/space; the last space is the trailing character gap
    function automatic int exp_run(input int code, input int j);
        string s;
        int e;
        s = morse[code];
        e = j / 2;
        if (j % 2 == 0) return (s[e] == 8'h2D) ? 3 * U : U;
        return (e == s.len() - 1) ? 3 * U : U;
    endfunction

    function automatic int tot_cycles(input int code);
        int sum = 0;
        for (int j = 0; j < exp_nruns(code); j++) sum += exp_run(code, j);
        return sum;
    endfunction

    task automatic chk(input bit ok, input string name, input int act, input int exp_v);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; the model decides acceptance
    task automatic drive(input logic s, input logic [5:0] c, input logic r);
        exp_t e;
        @(negedge CLK);
        start     = s;
        char_code = c;
        RST       = r;
        if (r) begin
            exp_q.delete();
            idle_at = cyc + 1;
        end else if (s && cyc >= idle_at) begin
            e.is_err = (c > 6'd35);
            e.code   = c;
            e.t      = cyc;
            exp_q.push_back(e);
            idle_at = e.is_err ? cyc + 1 : cyc + tot_cycles(int'(c)) + 1;
        end
    endtask

    task automatic send(input logic [5:0] c);
        drive(1'b1, c, 1'b0);
        drive(1'b0, 6'd0, 1'b0);
    endtask

    task automatic wait_idle();
        while (cyc < idle_at + 2) drive(1'b0, 6'd0, 1'b0);
    endtask

    int obs_runs [64];
    int obs_n = 0;
    int first_busy = 0;
    int ticks = 0;
    bit in_trace = 0;
    bit first_key = 0;
    bit last_key = 0;

    // Monitor: records the key waveform of each character and scores it on done/err
    initial begin
        exp_t e;
        int tot;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                chk(!(unit_tick && !busy), "tick_without_busy", int'(unit_tick), 0);
                chk(!(done && err), "done_and_err", int'(done & err), 0);
            end
            if (busy) begin
                if (!in_trace) begin
                    in_trace   = 1;
                    first_busy = cyc;
                    obs_n      = 0;
                    ticks      = 0;
                    first_key  = key;
                end
                if (obs_n == 0 || key != last_key) begin
                    if (obs_n < 64) obs_runs[obs_n] = 1;
                    obs_n++;
                end else if (obs_n <= 64) begin
                    obs_runs[obs_n-1]++;
                end
                last_key = key;
                if (unit_tick) begin
                    ticks++;
                    chk((cyc - first_busy) % U == U - 1, "tick_phase", (cyc - first_busy) % U, U - 1);
                end
            end else begin
                if (done || err) begin
                    if (exp_q.size() == 0) begin
                        chk(0, done ? "unexpected_done" : "unexpected_err", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        if (done) begin
                            chk(!e.is_err, "done_kind", int'(e.is_err), 0);
                            if (!e.is_err) begin
                                tot = tot_cycles(int'(e.code));
                                chk(obs_n == exp_nruns(int'(e.code)), "run_count", obs_n, exp_nruns(int'(e.code)));
                                if (obs_n == exp_nruns(int'(e.code))) begin
                                    for (int j = 0; j < obs_n; j++)
                                        chk(obs_runs[j] == exp_run(int'(e.code), j),
                                            $sformatf("run%0d_code%0d", j, e.code), obs_runs[j], exp_run(int'(e.code), j));
                                end
                                chk(first_key == 1'b1, "first_key", int'(first_key), 1);
                                chk(in_trace && first_busy == e.t + 1, "busy_start", first_busy, e.t + 1);
                                chk(cyc == e.t + tot + 1, "done_cycle", cyc, e.t + tot + 1);
                                chk(ticks == tot / U, "tick_count", ticks, tot / U);
                            end
                        end else begin
                            chk(e.is_err, "err_kind", int'(e.is_err), 1);
                            chk(cyc == e.t + 1, "err_cycle", cyc, e.t + 1);
                            chk(!key, "err_key", int'(key), 0);
                        end
                    end
                end
                in_trace = 0;
            end
        end
    end

    // Stimulus: reset, directed characters, abort, back-to-back, then random traffic
    initial begin
        int t0;
        start     = 1'b0;
        char_code = 6'd0;
        RST       = 1'b1;
        repeat (3) drive(1'b0, 6'd0, 1'b1);
        drive(1'b0, 6'd0, 1'b0);
        chk(key == 1'b0, "rst_key", int'(key), 0);
        chk(busy == 1'b0, "rst_busy", int'(busy), 0);
        chk(unit_tick == 1'b0, "rst_tick", int'(unit_tick), 0);
        chk(done == 1'b0, "rst_done", int'(done), 0);
        chk(err == 1'b0, "rst_err", int'(err), 0);

        send(6'd4);  wait_idle();
        send(6'd0);  wait_idle();
        send(6'd26); wait_idle();
        send(6'd40); wait_idle();
        send(6'd17); wait_idle();

        drive(1'b1, 6'd19, 1'b0);
        t0 = cyc;
        drive(1'b0, 6'd0, 1'b0);
        drive(1'b0, 6'd0, 1'b0);
        drive(1'b1, 6'd4, 1'b0);
        drive(1'b0, 6'd0, 1'b0);
        drive(1'b0, 6'd0, 1'b0);
        chk(key == 1'b1 && busy == 1'b1, "dash_before_rst", int'({key, busy}), 3);
        drive(1'b0, 6'd0, 1'b1);
        drive(1'b0, 6'd0, 1'b0);
        chk(cyc == t0 + 7 && key == 1'b0, "abort_key", int'(key), 0);
        chk(busy == 1'b0, "abort_busy", int'(busy), 0);
        wait_idle();
        send(6'd4); wait_idle();

        drive(1'b1, 6'd4, 1'b0);
        t0 = idle_at;
        while (cyc < t0) drive(1'b1, 6'd4, 1'b0);
        drive(1'b0, 6'd0, 1'b0);
        chk(cyc == t0 + 1 && key == 1'b1, "b2b_key_rise", int'(key), 1);
        wait_idle();

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 3) == 0)
                drive(1'b1, 6'($urandom_range(0, 63)), 1'b0);
            else
                drive(1'b1 & ($urandom_range(0, 3) == 0), 6'($urandom_range(0, 35)), 1'b0);
        end
        wait_idle();
        repeat (4) drive(1'b0, 6'd0, 1'b0);
        chk(exp_q.size() == 0, "pending_expectations", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
